// File: rtl/tristate_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tristate_bus_arbiter_pkg
//  Description : Shared state encodings, default sizes and width helpers for
//                the tri-state bus arbiter and its round-robin selector.
//  Revision    : 1.0  initial release
// ============================================================================
package tristate_bus_arbiter_pkg;

    // Arbiter FSM states; encodings are fixed so waveforms stay readable
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } arb_state_t;

    localparam int c_def_n_req       = 4;
    localparam int c_def_max_hold    = 8;
    localparam int c_def_turn_cycles = 1;

    // Index width for n requesters, never narrower than one bit
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Width of a counter that must reach maxval inclusive
    function automatic int cnt_width(input int maxval);
        return (maxval <= 1) ? 1 : $clog2(maxval + 1);
    endfunction

endpackage : tristate_bus_arbiter_pkg
`default_nettype wire

// File: rtl/tristate_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : tristate_bus_arbiter_if
//  Description : Request/release and grant/driver-enable bundle between the
//                requesters and the tri-state bus arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
interface tristate_bus_arbiter_if
    import tristate_bus_arbiter_pkg::*;
#(
    parameter int N_REQ = c_def_n_req
) ();

    localparam int c_owner_w = idx_width(N_REQ);

    logic [N_REQ-1:0]     req;
    logic [N_REQ-1:0]     done;
    logic [N_REQ-1:0]     grant;
    logic [N_REQ-1:0]     drv_en;
    logic [c_owner_w-1:0] owner;
    logic                 bus_idle;
    logic                 timeout;

    // Arbiter side
    modport master (
        input  req,
        input  done,
        output grant,
        output drv_en,
        output owner,
        output bus_idle,
        output timeout
    );

    // Requester / driver side
    modport slave (
        output req,
        output done,
        input  grant,
        input  drv_en,
        input  owner,
        input  bus_idle,
        input  timeout
    );

endinterface : tristate_bus_arbiter_if
`default_nettype wire

// File: rtl/tristate_bus_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : tristate_bus_arbiter_rr_pick
//  Description : Combinational round-robin selector. Searches req starting at
//                ptr, wrapping from N_REQ-1 to 0, and returns the first
//                asserted requester as one-hot pick plus its index.
//  Revision    : 1.0  initial release
// ============================================================================
module tristate_bus_arbiter_rr_pick
    import tristate_bus_arbiter_pkg::*;
#(
    parameter  int N_REQ   = c_def_n_req,
    localparam int c_idx_w = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0]   req,
    input  logic [c_idx_w-1:0] ptr,
    output logic [N_REQ-1:0]   pick,
    output logic [c_idx_w-1:0] pick_idx,
    output logic               valid
);

    logic [c_idx_w-1:0] w_cand;

    // First requester at or after ptr in circular order wins
    always_comb begin
        pick     = '0;
        pick_idx = '0;
        valid    = 1'b0;
        w_cand   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_cand = c_idx_w'((int'(ptr) + i) % N_REQ);
            if (!valid && req[w_cand]) begin
                valid        = 1'b1;
                pick[w_cand] = 1'b1;
                pick_idx     = w_cand;
            end
        end
    end

endmodule : tristate_bus_arbiter_rr_pick
`default_nettype wire

// File: rtl/tristate_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tristate_bus_arbiter
//  Description : Round-robin owner of a shared tri-state data bus. Grants one
//                driver at a time, bounds each tenure to MAX_HOLD cycles and
//                keeps every driver disabled for TURN_CYCLES cycles between
//                owners so two drivers never contend.
//  Revision    : 1.0  initial release
// ============================================================================
module tristate_bus_arbiter
    import tristate_bus_arbiter_pkg::*;
#(
    parameter int N_REQ       = c_def_n_req,
    parameter int MAX_HOLD    = c_def_max_hold,
    parameter int TURN_CYCLES = c_def_turn_cycles
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    tristate_bus_arbiter_if.master bus
);

    localparam int c_idx_w  = idx_width(N_REQ);
    localparam int c_hold_w = cnt_width(MAX_HOLD);
    localparam int c_turn_w = cnt_width(TURN_CYCLES);

    localparam logic [c_idx_w-1:0]  c_last_idx = c_idx_w'(N_REQ - 1);
    localparam logic [c_hold_w-1:0] c_hold_max = c_hold_w'(MAX_HOLD);
    localparam logic [c_turn_w-1:0] c_turn_max = c_turn_w'(TURN_CYCLES);

    arb_state_t          r_state,    w_state_nxt;
    logic [N_REQ-1:0]    r_grant,    w_grant_nxt;
    logic [c_idx_w-1:0]  r_owner,    w_owner_nxt;
    logic [c_idx_w-1:0]  r_rr_ptr,   w_rr_ptr_nxt;
    logic [c_hold_w-1:0] r_hold_cnt, w_hold_nxt;
    logic [c_turn_w-1:0] r_turn_cnt, w_turn_nxt;
    logic                r_timeout,  w_timeout_nxt;
    logic                r_bus_idle;

    logic [N_REQ-1:0]    w_pick;
    logic [c_idx_w-1:0]  w_pick_idx;
    logic                w_pick_valid;

    logic                w_own_done;
    logic                w_own_req;
    logic                w_hold_max;
    logic [c_idx_w-1:0]  w_owner_inc;

    tristate_bus_arbiter_rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req      (bus.req),
        .ptr      (r_rr_ptr),
        .pick     (w_pick),
        .pick_idx (w_pick_idx),
        .valid    (w_pick_valid)
    );

    // Release conditions seen from the current owner's point of view
    assign w_own_done  = bus.done[r_owner];
    assign w_own_req   = bus.req[r_owner];
    assign w_hold_max  = (r_hold_cnt == c_hold_max);
    assign w_owner_inc = (r_owner == c_last_idx) ? '0 : r_owner + 1'b1;

    // Next-state and next-output decode; every register defaults to holding
    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_owner_nxt   = r_owner;
        w_rr_ptr_nxt  = r_rr_ptr;
        w_hold_nxt    = r_hold_cnt;
        w_turn_nxt    = r_turn_cnt;
        w_timeout_nxt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = ST_GRANT;
                    w_grant_nxt = w_pick;
                    w_owner_nxt = w_pick_idx;
                    w_hold_nxt  = c_hold_w'(1);
                end
            end

            ST_GRANT: begin
                if (w_own_done || !w_own_req || w_hold_max) begin
                    // Previous owner drops to lowest priority next round
                    w_state_nxt   = ST_TURN;
                    w_grant_nxt   = '0;
                    w_rr_ptr_nxt  = w_owner_inc;
                    w_turn_nxt    = c_turn_w'(1);
                    // Only a purely forced end counts as a timeout
                    w_timeout_nxt = w_hold_max && !w_own_done && w_own_req;
                end else begin
                    w_hold_nxt = r_hold_cnt + 1'b1;
                end
            end

            ST_TURN: begin
                if (r_turn_cnt != c_turn_max) begin
                    w_turn_nxt = r_turn_cnt + 1'b1;
                end else if (w_pick_valid) begin
                    w_state_nxt = ST_GRANT;
                    w_grant_nxt = w_pick;
                    w_owner_nxt = w_pick_idx;
                    w_hold_nxt  = c_hold_w'(1);
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // State and output registers; reset clears the driver enables at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_hold_cnt <= '0;
            r_turn_cnt <= '0;
            r_timeout  <= 1'b0;
            r_bus_idle <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_owner    <= w_owner_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_turn_cnt <= w_turn_nxt;
            r_timeout  <= w_timeout_nxt;
            r_bus_idle <= (w_grant_nxt == '0);
        end
    end

    // Driver enables mirror the grant register exactly
    assign bus.grant    = r_grant;
    assign bus.drv_en   = r_grant;
    assign bus.owner    = r_owner;
    assign bus.bus_idle = r_bus_idle;
    assign bus.timeout  = r_timeout;

endmodule : tristate_bus_arbiter
`default_nettype wire
